// File: rtl/axi4_ram.sv
// axi4_ram: AXI4 slave backed by on-chip RAM.
//
// The memory is split into one byte-wide RAM per strobe lane so that a
// strobed write only touches its own lane. Reads are combinational out of
// the lanes and registered into rdata. A write to the same word on the same
// edge therefore lands after the read has sampled, and the read sees old data.
// The write engine (AW/W/B) and read engine (AR/R) are independent FSMs.
// Each accepts one transaction at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axi_aw*           write address channel (lock/cache/prot ignored)
//   s_axi_w*            write data channel (wlast ignored; beat count from awlen)
//   s_axi_b*            write response channel (always OKAY)
//   s_axi_ar*           read address channel (lock/cache/prot ignored)
//   s_axi_r*            read data channel (always OKAY)

// One byte lane of the memory array: synchronous write, asynchronous read.
module axi4_ram_lane #(
    parameter int IDX_W = 13
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [0:(1<<IDX_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module axi4_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - LSB;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } burst_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    // FIXED holds the address; INCR, WRAP and reserved all step by 2^size,
    // modulo the address space.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        if (burst == 2'b00) return a;
        return a + (ADDR_WIDTH'(1) << size);
    endfunction

    // Holds the address-channel readies low until the first edge after reset.
    logic live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- write engine ----------------
    wstate_t wstate, wstate_nxt;
    burst_t  wb;
    logic [7:0] wcnt;
    logic aw_fire, w_fire;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;

    always_comb begin
        wstate_nxt    = wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate)
            W_IDLE: begin
                s_axi_awready = live;
                if (s_axi_awvalid && live) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && wcnt == wb.len) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_IDLE;
            wb     <= '0;
            wcnt   <= '0;
        end else begin
            wstate <= wstate_nxt;
            if (aw_fire) begin
                wb   <= '{s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst};
                wcnt <= '0;
            end else if (w_fire) begin
                wb.addr <= next_addr(wb.addr, wb.size, wb.burst);
                wcnt    <= wcnt + 8'd1;
            end
        end
    end

    assign s_axi_bid   = wb.id;
    assign s_axi_bresp = 2'b00;

    // ---------------- read engine ----------------
    rstate_t rstate, rstate_nxt;
    logic [ADDR_WIDTH-1:0] raddr;   // address of the next beat to fetch
    logic [7:0] rlen, rcnt;
    logic [2:0] rsize;
    logic [1:0] rburst;
    logic ar_fire, r_fire;
    logic [IDX_W-1:0] rd_idx;
    logic [STRB_WIDTH-1:0][7:0] mem_rd;

    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign r_fire  = s_axi_rvalid & s_axi_rready;

    always_comb begin
        rstate_nxt    = rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rstate)
            R_IDLE: begin
                s_axi_arready = live;
                if (s_axi_arvalid && live) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Beat 0 is fetched straight from araddr so it is ready one cycle after AR.
    assign rd_idx = (rstate == R_IDLE) ? s_axi_araddr[ADDR_WIDTH-1:LSB]
                                       : raddr[ADDR_WIDTH-1:LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate      <= R_IDLE;
            raddr       <= '0;
            rlen        <= '0;
            rcnt        <= '0;
            rsize       <= '0;
            rburst      <= '0;
            s_axi_rid   <= '0;
            s_axi_rdata <= '0;
            s_axi_rlast <= 1'b0;
        end else begin
            rstate <= rstate_nxt;
            if (ar_fire) begin
                s_axi_rid   <= s_axi_arid;
                rlen        <= s_axi_arlen;
                rsize       <= s_axi_arsize;
                rburst      <= s_axi_arburst;
                raddr       <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arburst);
                rcnt        <= '0;
                s_axi_rdata <= mem_rd;
                s_axi_rlast <= (s_axi_arlen == 8'd0);
            end else if (r_fire) begin
                if (s_axi_rlast) begin
                    s_axi_rlast <= 1'b0;
                end else begin
                    s_axi_rdata <= mem_rd;
                    rcnt        <= rcnt + 8'd1;
                    s_axi_rlast <= (rcnt + 8'd1 == rlen);
                    raddr       <= next_addr(raddr, rsize, rburst);
                end
            end
        end
    end

    assign s_axi_rresp = 2'b00;

    // ---------------- memory lanes ----------------
    for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_lane
        axi4_ram_lane #(.IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .we    (w_fire & s_axi_wstrb[g]),
            .waddr (wb.addr[ADDR_WIDTH-1:LSB]),
            .wdata (s_axi_wdata[g*8 +: 8]),
            .raddr (rd_idx),
            .rdata (mem_rd[g])
        );
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot};
endmodule

// File: tb/tb_axi4_ram.sv
// tb_axi4_ram: directed self-checking bench for axi4_ram at DATA_WIDTH=64.
module tb_axi4_ram;
    localparam int DW = 64;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0, awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0, wvalid = 1'b0, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0, arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] rbuf [0:7];

    always #5 clk = ~clk;

    axi4_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_rid(rid),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit fire = 0;
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        do begin fire = awready; tick(); n++; end while (!fire && n < 50);
        awvalid = 1'b0;
        chk("aw_handshake", 64'(fire), 64'd1);
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s);
        bit fire = 0;
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        do begin fire = wready; tick(); n++; end while (!fire && n < 50);
        wvalid = 1'b0;
        chk("w_handshake", 64'(fire), 64'd1);
    endtask

    task automatic b_take(input logic [7:0] id);
        bit fire = 0;
        int n = 0;
        bready = 1'b1;
        do begin
            fire = bvalid;
            if (fire) begin
                chk("bid", 64'(bid), 64'(id));
                chk("bresp", 64'(bresp), 64'd0);
            end
            tick(); n++;
        end while (!fire && n < 50);
        bready = 1'b0;
        chk("b_handshake", 64'(fire), 64'd1);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        bit fire = 0;
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        do begin fire = arready; tick(); n++; end while (!fire && n < 50);
        arvalid = 1'b0;
        chk("ar_handshake", 64'(fire), 64'd1);
        chk("r_latency", 64'(rvalid), 64'd1);
    endtask

    // Collects n beats into rbuf; with toggle set, rready alternates 1/0.
    task automatic r_take(input int n, input bit toggle, input logic [7:0] id);
        int b = 0;
        int cyc = 0;
        logic [63:0] held;
        while (b < n && cyc < 200) begin
            rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (rvalid && rready) begin
                rbuf[b] = rdata;
                chk("rlast", 64'(rlast), 64'(b == n - 1));
                chk("rid", 64'(rid), 64'(id));
                b++;
                tick();
            end else if (rvalid) begin
                held = rdata;
                tick();
                chk("r_stable", rdata, held);
            end else begin
                tick();
            end
            cyc++;
        end
        rready = 1'b0;
        chk("r_beats", 64'(b), 64'(n));
        chk("r_done_rvalid", 64'(rvalid), 64'd0);
        chk("r_done_arready", 64'(arready), 64'd1);
    endtask

    task automatic write1(input logic [15:0] addr, input logic [63:0] d, input logic [7:0] s);
        aw_send(8'h11, addr, 8'd0, 3'd3, 2'b01);
        w_beat(d, s);
        b_take(8'h11);
    endtask

    task automatic read1(input logic [15:0] addr, input logic [63:0] exp, input string tag);
        ar_send(8'h22, addr, 8'd0, 2'b01);
        r_take(1, 1'b0, 8'h22);
        chk(tag, rbuf[0], exp);
    endtask

    initial begin
        // reset
        repeat (3) tick();
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_ids", 64'({bid, rid}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        chk("rel_awready_pre", 64'(awready), 64'd0);
        tick();
        chk("rel_awready", 64'(awready), 64'd1);
        chk("rel_arready", 64'(arready), 64'd1);

        // single write then read
        aw_send(8'd5, 16'h0100, 8'd0, 3'd3, 2'b01);
        chk("aw_wready", 64'(wready), 64'd1);
        chk("aw_awready_low", 64'(awready), 64'd0);
        w_beat(64'h1122334455667788, 8'hFF);
        chk("w_bvalid", 64'(bvalid), 64'd1);
        chk("w_wready_low", 64'(wready), 64'd0);
        b_take(8'd5);
        chk("b_awready", 64'(awready), 64'd1);
        ar_send(8'd7, 16'h0100, 8'd0, 2'b01);
        r_take(1, 1'b0, 8'd7);
        chk("single_rdata", rbuf[0], 64'h1122334455667788);

        // strobed write
        write1(16'h0200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        write1(16'h0200, 64'h0, 8'h0F);
        read1(16'h0200, 64'hFFFF_FFFF_0000_0000, "strobe_rdata");

        // INCR burst, read with backpressure
        aw_send(8'd1, 16'h0300, 8'd3, 3'd3, 2'b01);
        for (int i = 1; i <= 4; i++) w_beat(64'(i), 8'hFF);
        b_take(8'd1);
        ar_send(8'd2, 16'h0300, 8'd3, 2'b01);
        r_take(4, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) chk("incr_beat", rbuf[i], 64'(i + 1));

        // FIXED burst: every beat hits 0x400, neighbour untouched
        write1(16'h0408, 64'hDEAD_BEEF_0408_0408, 8'hFF);
        aw_send(8'd3, 16'h0400, 8'd2, 3'd3, 2'b00);
        w_beat(64'hAAAA, 8'hFF);
        w_beat(64'hBBBB, 8'hFF);
        w_beat(64'hCCCC, 8'hFF);
        b_take(8'd3);
        read1(16'h0400, 64'hCCCC, "fixed_last");
        read1(16'h0408, 64'hDEAD_BEEF_0408_0408, "fixed_neighbour");

        // INCR across the top of memory wraps to address 0
        aw_send(8'd4, 16'hFFF8, 8'd1, 3'd3, 2'b01);
        w_beat(64'h7777_0000_FFF8, 8'hFF);
        w_beat(64'h8888_0000_0000, 8'hFF);
        b_take(8'd4);
        read1(16'hFFF8, 64'h7777_0000_FFF8, "wrap_top");
        read1(16'h0000, 64'h8888_0000_0000, "wrap_zero");

        // read runs to completion while the write engine sits in W_DATA
        aw_send(8'd6, 16'h0500, 8'd1, 3'd3, 2'b01);
        chk("conc_wready", 64'(wready), 64'd1);
        ar_send(8'd8, 16'h0300, 8'd3, 2'b01);
        r_take(4, 1'b0, 8'd8);
        for (int i = 0; i < 4; i++) chk("conc_read", rbuf[i], 64'(i + 1));
        w_beat(64'h5005, 8'hFF);
        w_beat(64'h5006, 8'hFF);
        b_take(8'd6);
        ar_send(8'd9, 16'h0500, 8'd1, 2'b01);
        r_take(2, 1'b0, 8'd9);
        chk("conc_w0", rbuf[0], 64'h5005);
        chk("conc_w1", rbuf[1], 64'h5006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
